// File: rtl/ram_write_scheduler.sv
// Shares the RAM write port between decompressor, file loader and layer input.
// Round-robin grant, mux select sequencing, burst address/length counting, Done pulse.
module ram_write_scheduler #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              DecompReq,
  input  logic              FileReq,
  input  logic              LayerReq,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [LEN_W-1:0]  XferLen,
  input  logic              DecompValid,
  input  logic              FileValid,
  input  logic              LayerValid,
  output logic              DecompReady,
  output logic              FileReady,
  output logic              LayerReady,
  output logic              Load,
  output logic              Image,
  output logic              Layer,
  output logic              RamWe,
  output logic [ADDR_W-1:0] RamAddr,
  output logic [1:0]        GrantId,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e            state_q;
  logic [2:0]        sel_q;
  logic [1:0]        grant_q;
  logic [1:0]        last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic              busy_q;
  logic              done_q;

  logic [2:0] req;
  logic [1:0] winner;
  logic       gnt_valid;
  logic       in_xfer;

  assign req = {LayerReq, FileReq, DecompReq};

  // Search starts at the source after the last granted one (ids 1..3).
  always_comb begin
    winner = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      logic [2:0] cand;
      cand = {1'b0, last_q} + 3'(i);
      if (cand > 3'd3) cand = cand - 3'd3;
      if (winner == 2'd0 && req[cand[1:0] - 2'd1]) winner = cand[1:0];
    end
  end

  always_comb begin
    gnt_valid = 1'b0;
    unique case (grant_q)
      2'd1:    gnt_valid = DecompValid;
      2'd2:    gnt_valid = FileValid;
      2'd3:    gnt_valid = LayerValid;
      default: gnt_valid = 1'b0;
    endcase
  end

  assign in_xfer     = (state_q == StXfer);
  assign RamWe       = in_xfer & gnt_valid;
  assign DecompReady = in_xfer && (grant_q == 2'd1);
  assign FileReady   = in_xfer && (grant_q == 2'd2);
  assign LayerReady  = in_xfer && (grant_q == 2'd3);

  assign {Load, Image, Layer} = sel_q;
  assign RamAddr = addr_q;
  assign GrantId = grant_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= 3'b000;
      grant_q <= 2'd0;
      last_q  <= 2'd3;
      addr_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (winner != 2'd0) begin
            grant_q <= winner;
            addr_q  <= BaseAddr;
            rem_q   <= XferLen;
            if (XferLen == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              sel_q   <= 3'b000;
            end else begin
              state_q <= StXfer;
              busy_q  <= 1'b1;
              unique case (winner)
                2'd1:    sel_q <= 3'b100;
                2'd2:    sel_q <= 3'b110;
                default: sel_q <= 3'b001;
              endcase
            end
          end
        end
        StXfer: begin
          if (gnt_valid) begin
            addr_q <= addr_q + ADDR_W'(1);
            rem_q  <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              sel_q   <= 3'b000;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          last_q  <= grant_q;
          grant_q <= 2'd0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_write_scheduler.sv
// Randomised bench for ram_write_scheduler against a burst-level reference model.
module tb_ram_write_scheduler;

  logic        clk;
  logic        rst_n;
  logic        DecompReq, FileReq, LayerReq;
  logic [15:0] BaseAddr;
  logic [15:0] XferLen;
  logic        DecompValid, FileValid, LayerValid;
  logic        DecompReady, FileReady, LayerReady;
  logic        Load, Image, Layer;
  logic        RamWe;
  logic [15:0] RamAddr;
  logic [1:0]  GrantId;
  logic        Busy;
  logic        Done;

  int checks;
  int failures;
  int last_grant;

  ram_write_scheduler #(.ADDR_W(16), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .DecompReq(DecompReq), .FileReq(FileReq), .LayerReq(LayerReq),
    .BaseAddr(BaseAddr), .XferLen(XferLen),
    .DecompValid(DecompValid), .FileValid(FileValid), .LayerValid(LayerValid),
    .DecompReady(DecompReady), .FileReady(FileReady), .LayerReady(LayerReady),
    .Load(Load), .Image(Image), .Layer(Layer),
    .RamWe(RamWe), .RamAddr(RamAddr), .GrantId(GrantId), .Busy(Busy), .Done(Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] sel_of(input int id);
    case (id)
      1:       return 3'b100;
      2:       return 3'b110;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // pct < 0 selects the fixed valid pattern pat (LSB first) instead of random valids.
  task automatic do_burst(input logic [2:0] reqs, input logic [15:0] base, input logic [15:0] len,
                          input int pct, input logic [7:0] pat, input bit keep);
    int win, beats, cyc, c;
    logic gv;
    logic [2:0] vals;
    win = 0;
    for (int i = 1; i <= 3; i++) begin
      c = last_grant + i;
      if (c > 3) c -= 3;
      if (win == 0 && reqs[c-1]) win = c;
    end
    {LayerReq, FileReq, DecompReq} = reqs;
    BaseAddr = base;
    XferLen  = len;
    {LayerValid, FileValid, DecompValid} = 3'b000;
    @(negedge clk);
    if (!keep) {LayerReq, FileReq, DecompReq} = 3'b000;
    BaseAddr = 16'($urandom);
    XferLen  = 16'($urandom);
    #1;
    if (len != 0) begin
      check_eq("grant_id", 32'(GrantId), 32'(win));
      check_eq("grant_busy", 32'(Busy), 32'd1);
      check_eq("grant_sel", 32'({Load, Image, Layer}), 32'(sel_of(win)));
      beats = 0;
      cyc = 0;
      while (beats < int'(len) && cyc < 400) begin
        vals = 3'($urandom);
        gv = (pct < 0) ? pat[cyc % 8] : (int'($urandom_range(99)) < pct);
        vals[win-1] = gv;
        {LayerValid, FileValid, DecompValid} = vals;
        #1;
        check_eq("xfer_we", 32'(RamWe), 32'(gv));
        check_eq("xfer_addr", 32'(RamAddr), 32'(16'(base + 16'(beats))));
        check_eq("xfer_ready", 32'({LayerReady, FileReady, DecompReady}), 32'(3'b001 << (win-1)));
        check_eq("xfer_sel", 32'({Load, Image, Layer}), 32'(sel_of(win)));
        check_eq("xfer_done", 32'(Done), 32'd0);
        if (gv) beats++;
        cyc++;
        @(negedge clk);
      end
      if (beats < int'(len)) check_eq("timeout", 32'(beats), 32'(len));
    end
    {LayerValid, FileValid, DecompValid} = 3'($urandom);
    {LayerReq, FileReq, DecompReq} = 3'b000;
    #1;
    check_eq("done_pulse", 32'(Done), 32'd1);
    check_eq("done_busy", 32'(Busy), 32'd0);
    check_eq("done_we", 32'(RamWe), 32'd0);
    check_eq("done_sel", 32'({Load, Image, Layer}), 32'd0);
    check_eq("done_ready", 32'({LayerReady, FileReady, DecompReady}), 32'd0);
    check_eq("done_addr", 32'(RamAddr), 32'(16'(base + len)));
    @(negedge clk);
    #1;
    check_eq("idle_done", 32'(Done), 32'd0);
    check_eq("idle_grant", 32'(GrantId), 32'd0);
    last_grant = win;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, 32'({Load, Image, Layer, RamWe, Busy, Done, GrantId, DecompReady, FileReady,
                       LayerReady}), 32'd0);
    check_eq({tag, "_addr"}, 32'(RamAddr), 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    last_grant = 3;
    rst_n = 1'b0;
    {DecompReq, FileReq, LayerReq} = 3'b111;
    {DecompValid, FileValid, LayerValid} = 3'b111;
    BaseAddr = 16'h1234;
    XferLen = 16'd5;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Decomp first out of reset, then round-robin with all requests held.
    do_burst(3'b111, 16'h0200, 16'd2, 100, 8'h00, 1'b1);
    do_burst(3'b111, 16'h0300, 16'd2, 100, 8'h00, 1'b1);
    do_burst(3'b111, 16'h0400, 16'd2, 100, 8'h00, 1'b1);
    do_burst(3'b111, 16'h0500, 16'd2, 100, 8'h00, 1'b1);
    // Single file burst and stalled layer burst.
    do_burst(3'b010, 16'h0010, 16'd4, 100, 8'h00, 1'b0);
    do_burst(3'b100, 16'h0020, 16'd3, -1, 8'b0001_1001, 1'b0);
    // Boundaries: zero length, address wrap.
    do_burst(3'b001, 16'h0777, 16'd0, 100, 8'h00, 1'b0);
    do_burst(3'b010, 16'hFFFE, 16'd3, 100, 8'h00, 1'b0);

    for (int n = 0; n < 24; n++) begin
      logic [2:0] r;
      r = 3'($urandom_range(1, 7));
      do_burst(r, 16'($urandom), 16'($urandom_range(0, 6)), 60, 8'h00, 1'($urandom));
    end

    // Mid-burst reset after two beats.
    {LayerReq, FileReq, DecompReq} = 3'b001;
    BaseAddr = 16'h0100;
    XferLen = 16'd8;
    @(negedge clk);
    {LayerReq, FileReq, DecompReq} = 3'b000;
    DecompValid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("mid_addr", 32'(RamAddr), 32'h0102);
    check_eq("mid_busy", 32'(Busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    last_grant = 3;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_eq("post_busy", 32'(Busy), 32'd0);
      check_eq("post_we", 32'(RamWe), 32'd0);
      check_eq("post_grant", 32'(GrantId), 32'd0);
    end
    DecompValid = 1'b0;
    // Pointer restored by reset: decomp wins again.
    do_burst(3'b111, 16'h0900, 16'd1, 100, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
